// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants and FSM state type for the register-set dump reader.
package regfile_dump_reader_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int REG_COUNT = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Output word stream of the dump reader: valid/ready handshake plus payload.
interface regfile_dump_reader_if
    import regfile_dump_reader_pkg::*;
#(
    parameter int DATA_W = regfile_dump_reader_pkg::DATA_W,
    parameter int ADDR_W = regfile_dump_reader_pkg::ADDR_W
);

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/regfile_dump_reader_range_check.sv
// Tells whether wnum lies in the inclusive range idx..last, wrapping through
// the top of the register index space.
module regfile_dump_reader_range_check
    import regfile_dump_reader_pkg::*;
#(
    parameter int ADDR_W = regfile_dump_reader_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] idx,
    input  logic [ADDR_W-1:0] last,
    input  logic [ADDR_W-1:0] wnum,
    output logic              in_range
);

    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] offset;

    // Distances from idx taken modulo the index space turn the wrapped range into a single compare
    always_comb begin
        span     = last - idx;
        offset   = wnum - idx;
        in_range = (offset <= span);
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks a register range through one register-set read
// port, streams each word over valid/ready, and flags writes that race the dump.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int DATA_W = regfile_dump_reader_pkg::DATA_W,
    parameter int ADDR_W = regfile_dump_reader_pkg::ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     first,
    input  logic [ADDR_W-1:0]     last,
    output logic [ADDR_W-1:0]     rnum,
    input  logic [DATA_W-1:0]     rdata,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     wnum,
    regfile_dump_reader_if.master out_if,
    output logic                  busy,
    output logic                  done,
    output logic                  dirty
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] last_nxt;
    logic [ADDR_W-1:0] index_q;
    logic [ADDR_W-1:0] index_nxt;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_nxt;
    logic              last_flag_q;
    logic              last_flag_nxt;
    logic              dirty_q;
    logic              dirty_nxt;
    logic              out_valid_c;
    logic              wnum_in_range;

    regfile_dump_reader_range_check #(
        .ADDR_W (ADDR_W)
    ) u_range_check (
        .idx      (idx),
        .last     (last_q),
        .wnum     (wnum),
        .in_range (wnum_in_range)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            last_q      <= '0;
            index_q     <= '0;
            data_q      <= '0;
            last_flag_q <= 1'b0;
            dirty_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            last_q      <= last_nxt;
            index_q     <= index_nxt;
            data_q      <= data_nxt;
            last_flag_q <= last_flag_nxt;
            dirty_q     <= dirty_nxt;
        end
    end

    // Next-state, datapath updates, read address and status outputs
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        last_nxt      = last_q;
        index_nxt     = index_q;
        data_nxt      = data_q;
        last_flag_nxt = last_flag_q;
        dirty_nxt     = dirty_q;
        rnum          = '0;
        out_valid_c   = 1'b0;
        done          = 1'b0;
        busy          = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    last_nxt  = last;
                    idx_nxt   = first;
                    dirty_nxt = 1'b0;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rnum          = idx;
                data_nxt      = rdata;
                index_nxt     = idx;
                last_flag_nxt = (idx == last_q);
                state_nxt     = ST_SEND;
            end
            ST_SEND: begin
                out_valid_c = 1'b1;
                if (out_if.out_ready) begin
                    if (last_flag_q) begin
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt   = idx + ADDR_W'(1);
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // The word already latched for SEND is safe; only uncaptured words can go stale
        if ((state == ST_FETCH || (state == ST_SEND && wnum != index_q)) &&
            write && wnum != '0 && wnum_in_range) begin
            dirty_nxt = 1'b1;
        end
    end

    assign out_if.out_valid = out_valid_c;
    assign out_if.out_data  = data_q;
    assign out_if.out_index = index_q;
    assign out_if.out_last  = last_flag_q;
    assign dirty            = dirty_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: bench-side register set, a
// queue-based model of the expected word stream, and directed/random dumps.
module tb_regfile_dump_reader;
    import regfile_dump_reader_pkg::*;

    localparam int MODE_PLAIN   = 0;
    localparam int MODE_STALL   = 1;
    localparam int MODE_DIRTY   = 2;
    localparam int MODE_RESTART = 3;
    localparam int MODE_RANDOM  = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  first = '0;
    logic [4:0]  last  = '0;
    logic [4:0]  rnum;
    logic [31:0] rdata;
    logic        write = 1'b0;
    logic [4:0]  wnum  = '0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        dirty;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) out_if ();

    regfile_dump_reader #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .first  (first),
        .last   (last),
        .rnum   (rnum),
        .rdata  (rdata),
        .write  (write),
        .wnum   (wnum),
        .out_if (out_if),
        .busy   (busy),
        .done   (done),
        .dirty  (dirty)
    );

    // Register set: register 0 always reads zero, writes land on the clock edge
    logic [31:0] regs      [32];
    logic [31:0] prev_regs [32];
    assign rdata = (rnum == 5'd0) ? 32'd0 : regs[rnum];
    always @(posedge clk) begin
        prev_regs <= regs;
        if (write && wnum != 5'd0) regs[wnum] <= wdata;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: queue of indices still owed, one fetch cycle before each word,
    // a done cycle after the last transfer, dirty from writes to uncaptured words
    bit          m_busy, m_fetch, m_done, m_dirty, m_capture;
    int          m_q[$];
    logic [31:0] m_data;
    int          rx_idx[$];
    logic [31:0] rx_data[$];
    bit          rx_last[$];

    always @(negedge clk) begin
        bit exp_valid;
        int n;
        if (!rst) begin
            m_busy = 0; m_fetch = 0; m_done = 0; m_dirty = 0; m_capture = 0;
            m_q.delete();
        end else begin
            if (m_capture) begin
                m_data    = (m_q[0] == 0) ? 32'd0 : prev_regs[m_q[0]];
                m_capture = 0;
            end
            exp_valid = m_busy && !m_done && !m_fetch;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("dirty", 32'(dirty), 32'(m_dirty));
            chk("out_valid", 32'(out_if.out_valid), 32'(exp_valid));
            chk("rnum", 32'(rnum), m_fetch ? 32'(m_q[0]) : 32'd0);
            if (exp_valid) begin
                chk("out_index", 32'(out_if.out_index), 32'(m_q[0]));
                chk("out_last", 32'(out_if.out_last), 32'(m_q.size() == 1));
                chk("out_data", out_if.out_data, m_data);
                if (out_if.out_ready) begin
                    rx_idx.push_back(int'(out_if.out_index));
                    rx_data.push_back(out_if.out_data);
                    rx_last.push_back(out_if.out_last);
                end
            end
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end else if (!m_busy) begin
                if (start) begin
                    n = ((int'(last) - int'(first)) & 31) + 1;
                    m_q.delete();
                    for (int k = 0; k < n; k++) m_q.push_back((int'(first) + k) % 32);
                    m_busy  = 1;
                    m_fetch = 1;
                    m_dirty = 0;
                end
            end else begin
                if (write && wnum != 5'd0) begin
                    foreach (m_q[i]) if (m_q[i] == int'(wnum) && (m_fetch || i > 0)) m_dirty = 1;
                end
                if (m_fetch) begin
                    m_fetch   = 0;
                    m_capture = 1;
                end else if (out_if.out_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_done = 1;
                    else m_fetch = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one dump; bc counts cycles with busy high, stalls counts forced ready-low cycles
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                            input logic [4:0] wt, output int bc, output int stalls);
        int cyc;
        bit seen;
        bit wrote;
        bc = 0; stalls = 0; cyc = 0; seen = 0; wrote = 0;
        first = f; last = l; start = 1'b1; write = 1'b0; out_if.out_ready = 1'b1;
        step();
        start = 1'b0;
        if (busy) bc++;
        while (!seen && cyc < 600) begin
            start = 1'b0;
            write = 1'b0;
            out_if.out_ready = 1'b1;
            case (mode)
                MODE_STALL: begin
                    if (out_if.out_valid && out_if.out_index == 5'(f + 5'd2) && stalls < 5) begin
                        out_if.out_ready = 1'b0;
                        stalls++;
                    end
                end
                MODE_DIRTY: begin
                    if (rnum == 5'd5 && !wrote) begin
                        write = 1'b1; wnum = wt; wdata = $urandom; wrote = 1;
                    end
                end
                MODE_RESTART: begin
                    if (cyc == 3) begin
                        start = 1'b1; first = 5'd0; last = 5'd31;
                    end
                end
                MODE_RANDOM: begin
                    out_if.out_ready = ($urandom_range(0, 3) != 0);
                    write = ($urandom_range(0, 2) == 0);
                    wnum  = 5'($urandom);
                    wdata = $urandom;
                    start = ($urandom_range(0, 15) == 0);
                    first = 5'($urandom);
                    last  = 5'($urandom);
                end
                default: ;
            endcase
            step();
            cyc++;
            if (busy) bc++;
            if (done) seen = 1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        start = 1'b0; write = 1'b0; out_if.out_ready = 1'b1;
        step();
    endtask

    initial begin
        int bc, st, base;
        out_if.out_ready = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_if.out_valid), 32'd0);
        chk("rst_out_data", out_if.out_data, 32'd0);
        chk("rst_out_index", 32'(out_if.out_index), 32'd0);
        chk("rst_out_last", 32'(out_if.out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dirty", 32'(dirty), 32'd0);
        chk("rst_rnum", 32'(rnum), 32'd0);
        step();
        rst = 1'b1;
        step();

        for (int k = 1; k < REG_COUNT; k++) begin
            write = 1'b1; wnum = 5'(k); wdata = 32'h100 + 32'(k);
            step();
        end
        write = 1'b0;
        step();

        base = rx_idx.size();
        run_dump(5'd0, 5'd31, MODE_PLAIN, 5'd0, bc, st);
        chk("full_count", 32'(rx_idx.size() - base), 32'd32);
        chk("full_first_idx", 32'(rx_idx[base]), 32'd0);
        chk("full_reg0_data", rx_data[base], 32'd0);
        chk("full_idx5_data", rx_data[base + 5], 32'h105);
        chk("full_last_idx", 32'(rx_idx[base + 31]), 32'd31);
        chk("full_last_data", rx_data[base + 31], 32'h11F);
        chk("full_last_flag", 32'(rx_last[base + 31]), 32'd1);
        chk("full_mid_flag", 32'(rx_last[base + 30]), 32'd0);
        chk("full_busy_cycles", 32'(bc), 32'd65);
        chk("full_dirty", 32'(dirty), 32'd0);

        base = rx_idx.size();
        run_dump(5'd30, 5'd1, MODE_PLAIN, 5'd0, bc, st);
        chk("wrap_count", 32'(rx_idx.size() - base), 32'd4);
        chk("wrap_idx0", 32'(rx_idx[base]), 32'd30);
        chk("wrap_idx1", 32'(rx_idx[base + 1]), 32'd31);
        chk("wrap_idx2", 32'(rx_idx[base + 2]), 32'd0);
        chk("wrap_idx3", 32'(rx_idx[base + 3]), 32'd1);
        chk("wrap_data0", rx_data[base], 32'h11E);
        chk("wrap_data2", rx_data[base + 2], 32'd0);
        chk("wrap_data3", rx_data[base + 3], 32'h101);
        chk("wrap_last", 32'(rx_last[base + 3]), 32'd1);
        chk("wrap_busy_cycles", 32'(bc), 32'd9);

        base = rx_idx.size();
        run_dump(5'd0, 5'd5, MODE_STALL, 5'd0, bc, st);
        chk("stall_cycles", 32'(st), 32'd5);
        chk("stall_count", 32'(rx_idx.size() - base), 32'd6);
        for (int k = 0; k < 6; k++) chk("stall_order", 32'(rx_idx[base + k]), 32'(k));
        chk("stall_busy_cycles", 32'(bc), 32'd18);

        run_dump(5'd4, 5'd8, MODE_DIRTY, 5'd7, bc, st);
        chk("dirty_in_range", 32'(dirty), 32'd1);
        run_dump(5'd4, 5'd8, MODE_DIRTY, 5'd3, bc, st);
        chk("dirty_out_of_range", 32'(dirty), 32'd0);
        run_dump(5'd4, 5'd8, MODE_DIRTY, 5'd0, bc, st);
        chk("dirty_reg0", 32'(dirty), 32'd0);

        base = rx_idx.size();
        run_dump(5'd10, 5'd12, MODE_RESTART, 5'd0, bc, st);
        chk("restart_count", 32'(rx_idx.size() - base), 32'd3);
        chk("restart_first", 32'(rx_idx[base]), 32'd10);

        base = rx_idx.size();
        run_dump(5'd9, 5'd9, MODE_PLAIN, 5'd0, bc, st);
        chk("single_count", 32'(rx_idx.size() - base), 32'd1);
        chk("single_idx", 32'(rx_idx[base]), 32'd9);
        chk("single_last", 32'(rx_last[base]), 32'd1);
        chk("single_busy_cycles", 32'(bc), 32'd3);

        first = 5'd0; last = 5'd31; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10 && !out_if.out_valid; i++) step();
        chk("pre_reset_valid", 32'(out_if.out_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_if.out_valid), 32'd0);
        chk("mid_rst_out_data", out_if.out_data, 32'd0);
        chk("mid_rst_out_index", 32'(out_if.out_index), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_rnum", 32'(rnum), 32'd0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_no_done", 32'(done), 32'd0);
            chk("post_rst_idle", 32'(busy), 32'd0);
        end

        for (int t = 0; t < 25; t++) begin
            run_dump(5'($urandom), 5'($urandom), MODE_RANDOM, 5'd0, bc, st);
        end

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
